// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: sequencing controller for the 2-digit BCD calculator.
// Buttons are synchronised and edge-detected into single-cycle presses. The block holds the
// four operand digits and runs one add/sub/mul/div at a time. Divide uses a serial restoring
// divider, and every result then passes through a serial double-dabble BCD converter.
// Optional feature macro: CALC_DEBOUNCE_EN (per-button debounce counters of DEB_CYCLES).
module calc_op_sequencer #(
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_inc,
    input  logic [3:0]  btn_op,
    input  logic        btn_show,
    output logic [15:0] disp_digit,
    output logic        disp_neg,
    output logic        disp_err,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NB = 9;   // {show, op[3:0], inc[3:0]}

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_CONV, S_SHOW} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
    typedef enum logic       {M_OPERANDS, M_RESULT} mode_t;

    if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_param_check
        $error("calc_op_sequencer: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
    end

    // ------------------------------------------------------------------
    // Button input path
    // ------------------------------------------------------------------
    logic [NB-1:0] r_sync [SYNC_STAGES];
    logic [NB-1:0] w_level;
    logic [NB-1:0] r_prev;
    logic [NB-1:0] w_evt;
    logic [3:0]    w_evt_inc;
    logic [3:0]    w_evt_op;
    logic          w_evt_show;

    // Synchroniser chain for all raw button inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= {btn_show, btn_op, btn_inc};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] r_deb_cnt [NB];
    logic [NB-1:0]    r_deb;

    // Debounced level flips only after DEB_CYCLES consecutive cycles at the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb <= '0;
            for (int unsigned i = 0; i < NB; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_sync[SYNC_STAGES-1][i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    r_deb[i]     <= r_sync[SYNC_STAGES-1][i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    // Previous level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) r_prev <= '0;
        else     r_prev <= w_level;
    end

    assign w_evt      = w_level & ~r_prev;
    assign w_evt_inc  = w_evt[3:0];
    assign w_evt_op   = w_evt[7:4];
    assign w_evt_show = w_evt[8];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    mode_t       r_mode;
    op_t         r_op;
    op_t         w_op_sel;
    logic [3:0]  r_dig [4];
    logic [6:0]  w_num1;
    logic [6:0]  w_num2;
    logic [13:0] r_res;
    logic [6:0]  r_rem;
    logic [6:0]  r_quo;
    logic [7:0]  w_rem_sh;
    logic [6:0]  w_rem_nxt;
    logic [6:0]  w_quo_nxt;
    logic [29:0] r_conv;
    logic [29:0] w_conv_src;
    logic [29:0] w_conv_adj;
    logic [29:0] w_conv_nxt;
    logic [3:0]  r_cnt;
    logic [15:0] r_bcd;
    logic        r_neg;
    logic        r_err;
    logic        r_done;
    logic        w_any_op;
    logic        w_enter_show;

    assign w_num1   = 7'(r_dig[1]) * 7'd10 + 7'(r_dig[0]);
    assign w_num2   = 7'(r_dig[3]) * 7'd10 + 7'(r_dig[2]);
    assign w_any_op = |w_evt_op;

    // Lowest-index operation button wins
    always_comb begin
        w_op_sel = OP_ADD;
        if      (w_evt_op[0]) w_op_sel = OP_ADD;
        else if (w_evt_op[1]) w_op_sel = OP_SUB;
        else if (w_evt_op[2]) w_op_sel = OP_MUL;
        else if (w_evt_op[3]) w_op_sel = OP_DIV;
    end

    // One restoring-divide step: shift in next dividend bit, subtract if it fits
    always_comb begin
        w_rem_sh = {r_rem, r_quo[6]};
        if (w_rem_sh >= {1'b0, w_num1}) begin
            w_rem_nxt = 7'(w_rem_sh - {1'b0, w_num1});
            w_quo_nxt = {r_quo[5:0], 1'b1};
        end else begin
            w_rem_nxt = w_rem_sh[6:0];
            w_quo_nxt = {r_quo[5:0], 1'b0};
        end
    end

    // One double-dabble step; first CONV cycle seeds the shifter from the raw result
    always_comb begin
        w_conv_src = (r_cnt == 4'd0) ? {16'h0000, r_res} : r_conv;
        w_conv_adj = w_conv_src;
        for (int unsigned k = 0; k < 4; k++) begin
            if (w_conv_src[14 + 4*k +: 4] >= 4'd5)
                w_conv_adj[14 + 4*k +: 4] = w_conv_src[14 + 4*k +: 4] + 4'd3;
        end
        w_conv_nxt = {w_conv_adj[28:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; presses outside IDLE/SHOW are ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_op) w_state_nxt = S_LOAD;
            end
            S_SHOW: begin
                if (w_any_op)                       w_state_nxt = S_LOAD;
                else if (|w_evt_inc || w_evt_show)  w_state_nxt = S_IDLE;
            end
            S_LOAD: begin
                if (r_op == OP_DIV) w_state_nxt = (w_num1 == 7'd0) ? S_SHOW : S_DIV;
                else                w_state_nxt = S_CONV;
            end
            S_DIV: begin
                if (r_cnt == 4'd6) w_state_nxt = S_CONV;
            end
            S_CONV: begin
                if (r_cnt == 4'd13) w_state_nxt = S_SHOW;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_enter_show = (r_state != S_SHOW) && (w_state_nxt == S_SHOW);

    // Operand digits, operation latch, divider/converter iteration and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) r_dig[i] <= '0;
            r_mode <= M_OPERANDS;
            r_op   <= OP_ADD;
            r_res  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_conv <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_enter_show;
            case (r_state)
                S_IDLE, S_SHOW: begin
                    if (w_any_op) begin
                        r_op <= w_op_sel;
                    end else begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (w_evt_inc[i])
                                r_dig[i] <= (r_dig[i] == 4'd9) ? 4'd0 : r_dig[i] + 4'd1;
                        end
                        if (|w_evt_inc || w_evt_show) r_mode <= M_OPERANDS;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                    r_rem <= '0;
                    r_quo <= w_num2;
                    case (r_op)
                        OP_ADD:  r_res <= 14'(w_num2) + 14'(w_num1);
                        OP_SUB:  r_res <= (w_num1 > w_num2) ? 14'(w_num1 - w_num2)
                                                            : 14'(w_num2 - w_num1);
                        OP_MUL:  r_res <= 14'(w_num2) * 14'(w_num1);
                        default: r_res <= '0;
                    endcase
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == 4'd6) begin
                        r_res <= 14'(w_quo_nxt);
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_CONV: begin
                    r_conv <= w_conv_nxt;
                    r_cnt  <= r_cnt + 4'd1;
                end
                default: ;
            endcase
            // Display flags update together with done; only LOAD->SHOW is divide-by-zero
            if (w_enter_show) begin
                r_mode <= M_RESULT;
                r_bcd  <= (r_state == S_CONV) ? w_conv_nxt[29:14] : 16'h0000;
                r_err  <= (r_state == S_LOAD) && (r_op == OP_DIV);
                r_neg  <= (r_op == OP_SUB) && (w_num1 > w_num2);
            end
        end
    end

    // Outputs: busy from state, display muxed by mode
    always_comb begin
        busy = (r_state == S_LOAD) || (r_state == S_DIV) || (r_state == S_CONV);
        done = r_done;
        if (r_mode == M_RESULT) begin
            disp_digit = r_bcd;
            disp_neg   = r_neg;
            disp_err   = r_err;
        end else begin
            disp_digit = {r_dig[3], r_dig[2], r_dig[1], r_dig[0]};
            disp_neg   = 1'b0;
            disp_err   = 1'b0;
        end
    end

endmodule
